// File: rtl/sa_pkg.sv
// Shared constants for the systolic-array feeder rows: widths and feeder FSM state codes.
package sa_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W      = 8;
  localparam int STALL_W    = 16;
  localparam int DRAIN_W    = 5;

  typedef logic [1:0] feeder_state_t;

  localparam feeder_state_t ST_IDLE  = 2'd0;
  localparam feeder_state_t ST_RUN   = 2'd1;
  localparam feeder_state_t ST_DRAIN = 2'd2;
  localparam feeder_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Tile handshake, FIFO read side and PE row output of one skew feeder.
// master = array controller / FIFO / PE side, slave = the feeder itself.
interface sa_skew_feeder_if #(
  parameter int DATA_W = sa_pkg::DATA_W_DEF
);
  import sa_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  tile_len;
  logic              busy;
  logic              done;
  logic              fifo_rd_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] pe_in;
  logic              pe_valid;

  modport master (
    output start, tile_len, fifo_empty, fifo_dout,
    input  busy, done, fifo_rd_en, pe_in, pe_valid
  );

  modport slave (
    input  start, tile_len, fifo_empty, fifo_dout,
    output busy, done, fifo_rd_en, pe_in, pe_valid
  );

endinterface

// File: rtl/sa_delay_line.sv
// DEPTH-stage shift register of {valid,data}; DEPTH=0 collapses to wires.
module sa_delay_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_shift
      logic [DATA_W:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= {in_valid, in_data};
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign out_valid = stage[DEPTH-1][DATA_W];
      assign out_data  = stage[DEPTH-1][DATA_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/sa_skew_feeder.sv
// Pops one tile from the activation FIFO and feeds it to a PE row, delayed by SKEW cycles.
// Optional stall statistics (stall_cnt port) are built when SA_FEEDER_STATS_EN is defined.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKEW   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sa_skew_feeder_if.slave      bus
`ifdef SA_FEEDER_STATS_EN
  ,
  output logic [STALL_W-1:0]   stall_cnt
`endif
);

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SKEW + 1);

  feeder_state_t      state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               pop;
  logic               v1;
  logic               s0_valid;
  logic [DATA_W-1:0]  s0_data;

  assign pop            = (state == ST_RUN) && !bus.fifo_empty && (issued < len_q);
  assign bus.fifo_rd_en = pop;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

  // Zero-length tiles skip straight to DONE so the controller still sees a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      issued    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.tile_len != '0) begin
              state     <= ST_RUN;
              len_q     <= bus.tile_len;
              issued    <= '0;
              drain_cnt <= '0;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (pop) begin
            issued <= issued + LEN_W'(1);
            if (issued == len_q - LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= ST_DONE;
          else drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // fifo_dout is only meaningful the cycle after a pop, so gate it with v1 to keep bubbles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else begin
      v1       <= pop;
      s0_valid <= v1;
      s0_data  <= v1 ? bus.fifo_dout : '0;
    end
  end

  sa_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (SKEW)
  ) u_skew (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s0_valid),
    .in_data   (s0_data),
    .out_valid (bus.pe_valid),
    .out_data  (bus.pe_in)
  );

`ifdef SA_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      stall_cnt <= '0;
    end else if (state == ST_RUN && issued < len_q && bus.fifo_empty && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: directed tile scenarios plus random traffic,
// compared every cycle against an event-schedule model of the tile protocol.
module tb_sa_skew_feeder;

  localparam int DW   = 8;
  localparam int SKEW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_skew_feeder_if #(.DATA_W(DW)) bus ();

`ifdef SA_FEEDER_STATS_EN
  logic [sa_pkg::STALL_W-1:0] stall_cnt;
`endif

  sa_skew_feeder #(
    .DATA_W (DW),
    .SKEW   (SKEW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SA_FEEDER_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // FIFO contents shared by the environment (driven by DUT pops) and the model (its own pops).
  logic [DW-1:0] words[$];
  int            env_idx = 0;
  int            mdl_idx = 0;
  bit            refill  = 1'b0;
  bit            pend_pop = 1'b0;
  logic [DW-1:0] pend_word = '0;

  // Model: a tile is an acceptance cycle plus a schedule of pe words and a done cycle.
  bit            m_active = 1'b0;
  int            m_acc    = 0;
  int            m_len    = 0;
  int            m_issued = 0;
  int            m_done   = -1;
  int            m_stall  = 0;
  logic [DW-1:0] m_pe[int];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst_v, input bit st, input int len, input bit stall);
    bit            emp, busy_e, done_e, rd_e, pv_e;
    logic [DW-1:0] pi_e, w;
    @(negedge clk);
    if (refill) while (words.size() < env_idx + 4) words.push_back(DW'($urandom));
    rst_n          = rst_v;
    bus.fifo_dout  = pend_pop ? pend_word : DW'($urandom);
    pend_pop       = 1'b0;
    bus.start      = st;
    bus.tile_len   = 8'(len);
    emp            = stall || (env_idx >= words.size());
    bus.fifo_empty = emp;
    #1;
    busy_e = rst_v && m_active && (cyc > m_acc);
    done_e = busy_e && (cyc == m_done);
    rd_e   = busy_e && (m_issued < m_len) && !emp;
    pv_e   = rst_v && m_pe.exists(cyc);
    pi_e   = pv_e ? m_pe[cyc] : '0;
    checkOutput("busy",       32'(bus.busy),       32'(busy_e));
    checkOutput("done",       32'(bus.done),       32'(done_e));
    checkOutput("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(rd_e));
    checkOutput("pe_valid",   32'(bus.pe_valid),   32'(pv_e));
    checkOutput("pe_in",      32'(bus.pe_in),      32'(pi_e));
`ifdef SA_FEEDER_STATS_EN
    checkOutput("stall_cnt",  32'(stall_cnt),      rst_v ? 32'(m_stall) : 32'd0);
`endif
    if (bus.fifo_rd_en && !emp && env_idx < words.size()) begin
      pend_word = words[env_idx];
      env_idx++;
      pend_pop  = 1'b1;
    end
    if (!rst_v) begin
      m_active = 1'b0;
      m_stall  = 0;
      m_pe.delete();
    end else begin
      if (busy_e && m_issued < m_len && emp && m_stall < 65535) m_stall++;
      if (rd_e) begin
        w = (mdl_idx < words.size()) ? words[mdl_idx] : '0;
        mdl_idx++;
        m_pe[cyc + 2 + SKEW] = w;
        m_issued++;
        if (m_issued == m_len) m_done = cyc + SKEW + 3;
      end
      if (done_e) begin
        m_active = 1'b0;
      end else if (!m_active && st) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_len    = len;
        m_issued = 0;
        m_stall  = 0;
        m_done   = (len == 0) ? cyc + 1 : -1;
      end
    end
    cyc++;
  endtask

  task automatic loadWords(input int n);
    words.delete();
    env_idx = 0;
    mdl_idx = 0;
    for (int i = 0; i < n; i++) words.push_back(DW'($urandom_range(1, 255)));
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.tile_len   = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;

    // Reset held with start asserted, then release straight into a 4-word tile.
    repeat (3) applyStimulus(1'b0, 1'b1, 4, 1'b0);
    words = {8'd11, 8'd22, 8'd33, 8'd44};
    env_idx = 0;
    mdl_idx = 0;
    applyStimulus(1'b1, 1'b1, 4, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("tile4_pops", 32'(env_idx), 32'd4);

    // Underflow bubble: FIFO empty for three cycles after the first pop.
    loadWords(3);
    for (int t = 0; t < 15; t++) applyStimulus(1'b1, t == 0, 3, (t >= 2) && (t <= 4));
    checkOutput("bubble_pops", 32'(env_idx), 32'd3);

    // Zero-length tile.
    loadWords(2);
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("len0_pops", 32'(env_idx), 32'd0);

    // start held through the whole tile including the done cycle.
    refill = 1'b1;
    loadWords(0);
    for (int t = 0; t < 16; t++) applyStimulus(1'b1, t <= 10, (t == 0) ? 5 : 7, 1'b0);

    // Reset after two pops, then a fresh tile.
    applyStimulus(1'b1, 1'b1, 4, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b0, 0, 1'b0);

    // Random traffic with stalls, zero-length tiles, stray starts and rare resets.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 300) != 0,
                    ($urandom % 4) == 0,
                    (($urandom % 6) == 0) ? 0 : int'($urandom_range(1, 10)),
                    ($urandom % 3) == 0);
    end
    repeat (25) applyStimulus(1'b1, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
